// File: rtl/pll_rst_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock with bounded
// retries, then releases the downstream system reset and watches for lock loss.
module pll_rst_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int LOCK_STABLE    = 256,
    parameter int MAX_RETRY      = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       fail,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      retry_q, retry_d;
    logic [7:0]      lost_q, lost_d;
    logic [1:0]      sync_q;
    logic            locked_s;

    assign locked_s      = sync_q[1];
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

    // relock_req is a one-cycle pulse sampled on refclk; it only acts in RUN and FAIL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        state_d = S_RESET_PLL;
                        retry_d = retry_q + 2'd1;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = 2'd0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                // Lock loss wins over a simultaneous relock so the loss is counted once.
                if (!locked_s) begin
                    state_d = S_RESET_PLL;
                    retry_d = 2'd0;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end else if (relock_req) begin
                    state_d = S_RESET_PLL;
                    retry_d = 2'd0;
                end
            end
            S_FAIL: begin
                cnt_d = cnt_q;
                if (relock_req) begin
                    state_d = S_RESET_PLL;
                    retry_d = 2'd0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= 2'd0;
            lost_q    <= 8'd0;
            sync_q    <= 2'b00;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            fail      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pll_locked};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst   <= (state_d == S_RESET_PLL);
            sys_rst_n <= (state_d == S_RUN);
            fail      <= (state_d == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Bench for pll_rst_sequencer: directed lock/loss/retry/reset scenarios, each output change
// is checked against a queue of hand-computed {edge, outputs} records.
module tb_pll_rst_sequencer;

    localparam int W = 32;
    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int model_lost = 0;
    int total_losses = 0;
    bit mon_on = 1'b0;
    logic [15:0] mon_prev;
    logic [W-1:0] exp_q[$];

    pll_rst_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT(32),
        .LOCK_STABLE(8),
        .MAX_RETRY(2)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .fail(fail),
        .state(state),
        .retry_cnt(retry_cnt),
        .lock_lost_cnt(lock_lost_cnt)
    );

    // clock / edge counter
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [15:0] model_outs(input logic [2:0] st, input logic [1:0] rc,
                                               input logic [7:0] ll);
        return {st, st == S_RESET, st == S_RUN, st == S_FAIL, rc, ll};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {state, pll_rst, sys_rst_n, fail, retry_cnt, lock_lost_cnt};
    endfunction

    task automatic push(input int c, input logic [2:0] st, input logic [1:0] rc, input int ll);
        exp_q.push_back({16'(c), model_outs(st, rc, 8'(ll))});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // monitor: every change of the output vector consumes one expected record
    always @(negedge refclk) begin
        logic [15:0]  cur;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        #1;
        cur = dut_outs();
        if (mon_on && cur !== mon_prev) begin
            got = {16'(cyc), cur};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got edge=%0d out=%h, expected no change", cyc, cur);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL transition: got edge=%0d out=%h, expected edge=%0d out=%h",
                             got[31:16], got[15:0], exp[31:16], exp[15:0]);
                end
            end
        end
        mon_prev = cur;
    end

    // driver tasks (all start and end on a falling edge)
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    task automatic pulse_relock_at(input int e);
        wait_to(e - 1);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'(S_RESET));
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
        check({tag, "_lock_lost_cnt"}, 32'(lock_lost_cnt), 32'd0);
    endtask

    // From RUN with pll_locked high: drop lock (first sampled at edge p); optionally pulse
    // relock in the same FSM cycle and optionally re-acquire lock right away.
    task automatic loss_cycle(input bit with_relock, input bit reacquire, output int w);
        int p;
        p = cyc + 1;
        total_losses++;
        if (model_lost < 255) model_lost++;
        push(p + 2, S_RESET, 2'd0, model_lost);
        push(p + 6, S_WAIT, 2'd0, model_lost);
        if (reacquire) begin
            push(p + 7, S_STABLE, 2'd0, model_lost);
            push(p + 15, S_RUN, 2'd0, model_lost);
        end
        pll_locked = 1'b0;
        wait_to(p + 1);
        if (with_relock) relock_req = 1'b1;
        if (reacquire) pll_locked = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        wait_to(reacquire ? p + 16 : p + 8);
        w = p + 6;
    endtask

    task automatic relock_in_run();
        int r;
        r = cyc + 1;
        push(r, S_RESET, 2'd0, model_lost);
        push(r + 4, S_WAIT, 2'd0, model_lost);
        push(r + 5, S_STABLE, 2'd0, model_lost);
        push(r + 13, S_RUN, 2'd0, model_lost);
        pulse_relock_at(r);
        pulse_relock_at(r + 2);
        pulse_relock_at(r + 5);
        pulse_relock_at(r + 9);
        wait_to(r + 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int w;
        int r;
        int s;
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge refclk);
        #1;
        check_reset_values("por");
        mon_on = 1'b1;

        // normal lock: pll_rst for cycles 0-3, lock sampled at edge c0+10, RUN at c0+20
        @(negedge refclk);
        c0 = cyc;
        push(c0 + 4, S_WAIT, 2'd0, 0);
        push(c0 + 12, S_STABLE, 2'd0, 0);
        push(c0 + 20, S_RUN, 2'd0, 0);
        rst_n = 1'b1;
        wait_to(c0 + 9);
        pll_locked = 1'b1;
        wait_to(c0 + 24);

        // relock request in RUN; pulses in RESET_PLL/WAIT_LOCK/STABLE are ignored
        relock_in_run();

        // lock loss in RUN, then loss coinciding with relock (counted once)
        loss_cycle(1'b0, 1'b1, w);
        loss_cycle(1'b1, 1'b1, w);

        // lock never returns: two retries then FAIL
        loss_cycle(1'b0, 1'b0, w);
        push(w + 32, S_RESET, 2'd1, model_lost);
        push(w + 36, S_WAIT, 2'd1, model_lost);
        push(w + 68, S_RESET, 2'd2, model_lost);
        push(w + 72, S_WAIT, 2'd2, model_lost);
        push(w + 104, S_FAIL, 2'd2, model_lost);
        wait_to(w + 110);

        // relock out of FAIL, one more timeout, then a 3-cycle glitch in STABLE
        r = w + 111;
        s = r + 41;
        push(r, S_RESET, 2'd0, model_lost);
        push(r + 4, S_WAIT, 2'd0, model_lost);
        push(r + 36, S_RESET, 2'd1, model_lost);
        push(r + 40, S_WAIT, 2'd1, model_lost);
        push(s + 2, S_STABLE, 2'd1, model_lost);
        push(s + 8, S_WAIT, 2'd1, model_lost);
        push(s + 11, S_STABLE, 2'd1, model_lost);
        push(s + 19, S_RUN, 2'd0, model_lost);
        pulse_relock_at(r);
        pulse_relock_at(r + 2);
        wait_to(s - 1);
        pll_locked = 1'b1;
        wait_to(s + 5);
        pll_locked = 1'b0;
        wait_to(s + 8);
        pll_locked = 1'b1;
        pulse_relock_at(s + 10);
        pulse_relock_at(s + 13);
        wait_to(s + 22);

        // saturate the loss counter (past 256 losses)
        while (total_losses < 257) loss_cycle(1'b0, 1'b1, w);
        check("lost_saturated", 32'(lock_lost_cnt), 32'd255);

        // asynchronous reset while in WAIT_LOCK
        loss_cycle(1'b0, 1'b0, w);
        model_lost = 0;
        push(cyc, S_RESET, 2'd0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (3) @(negedge refclk);
        c0 = cyc;
        push(c0 + 4, S_WAIT, 2'd0, 0);
        rst_n = 1'b1;
        wait_to(c0 + 8);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
